frost32_mem_bus_ctrl: RTL and testbench

//  Memory-side controller directly downstream of the Frost32 CPU memory port. Consumes the
//  CPU's mem-access request (data, addr, access type, access size, req_mem_access), runs one

---
 rtl/frost32_mem_bus_ctrl_pkg.sv | 60 ++++++
 rtl/frost32_mem_lane_align.sv | 37 +++
 rtl/frost32_mem_bus_ctrl.sv | 156 +++++++++++++++
 tb/tb_frost32_mem_bus_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frost32_mem_bus_ctrl_pkg.sv
// Shared types and helpers for the Frost32 memory-side bus controller.
// Access encodings match the CPU memory port.
package PkgFrost32Cpu;

    typedef enum logic {
        DiatRead  = 1'b0,
        DiatWrite = 1'b1
    } DataInoutAccessType;

    typedef enum logic [1:0] {
        Dias32  = 2'd0,
        Dias16  = 2'd1,
        Dias8   = 2'd2,
        DiasBad = 2'd3
    } DataInoutAccessSize;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBus  = 2'd1,
        StDone = 2'd2
    } MemBusCtrlState;

    typedef struct packed {
        logic [31:0]        addr;
        logic [31:0]        data;
        DataInoutAccessType access_type;
        DataInoutAccessSize access_size;
    } MemBusReq;

    function automatic logic legal_access(
        input logic [31:0]        addr,
        input DataInoutAccessSize size
    );
        logic ok;
        ok = 1'b0;
        case (size)
            Dias32:  ok = (addr[1:0] == 2'b00);
            Dias16:  ok = (addr[0] == 1'b0);
            Dias8:   ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_en_for(
        input logic [31:0]        addr,
        input DataInoutAccessSize size
    );
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            Dias32:  be = 4'b1111;
            Dias16:  be = 4'b0011 << addr[1:0];
            Dias8:   be = 4'b0001 << addr[1:0];
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/frost32_mem_lane_align.sv
// Byte-lane steering: right-justify/mask read data, replicate write data.
// Purely combinational.
module frost32_mem_lane_align
    import PkgFrost32Cpu::*;
(
    input  logic [31:0]        rdata_i,
    input  logic [1:0]         rd_offset_i,
    input  DataInoutAccessSize rd_size_i,
    output logic [31:0]        rdata_o,
    input  logic [31:0]        wdata_i,
    input  DataInoutAccessSize wr_size_i,
    output logic [31:0]        wdata_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_i >> {rd_offset_i, 3'b000};
        rdata_o = 32'h0;
        case (rd_size_i)
            Dias32:  rdata_o = shifted;
            Dias16:  rdata_o = {16'h0, shifted[15:0]};
            Dias8:   rdata_o = {24'h0, shifted[7:0]};
            default: rdata_o = 32'h0;
        endcase
    end

    always_comb begin
        wdata_o = wdata_i;
        case (wr_size_i)
            Dias16:  wdata_o = {2{wdata_i[15:0]}};
            Dias8:   wdata_o = {4{wdata_i[7:0]}};
            default: wdata_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/frost32_mem_bus_ctrl.sv
// Frost32 memory bus controller: one word-addressed bus transaction per
// CPU request, with alignment/size checks and an ack timeout.
module frost32_mem_bus_ctrl
    import PkgFrost32Cpu::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_WIDTH      = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_req_mem_access,
    input  logic [31:0]        in_addr,
    input  logic [31:0]        in_data,
    input  DataInoutAccessType in_access_type,
    input  DataInoutAccessSize in_access_size,
    output logic [31:0]        out_data,
    output logic               out_wait_for_mem,
    output logic               out_bad_access,
    output logic               mem_req,
    output logic               mem_we,
    output logic [29:0]        mem_addr,
    output logic [3:0]         mem_byte_en,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata,
    input  logic               mem_ack
);

    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    MemBusCtrlState       state_q, state_d;
    MemBusReq             req_q, req_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]          out_data_q, out_data_d;
    logic                 wait_q, wait_d;
    logic                 bad_q, bad_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [29:0]          mem_addr_q, mem_addr_d;
    logic [3:0]           be_q, be_d;
    logic [31:0]          wdata_q, wdata_d;

    logic [31:0]          rdata_aligned;
    logic [31:0]          wdata_rep;

    // Read side uses the latched request; write side uses the live request.
    frost32_mem_lane_align u_align (
        .rdata_i     (mem_rdata),
        .rd_offset_i (req_q.addr[1:0]),
        .rd_size_i   (req_q.access_size),
        .rdata_o     (rdata_aligned),
        .wdata_i     (in_data),
        .wr_size_i   (in_access_size),
        .wdata_o     (wdata_rep)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        wait_d     = wait_q;
        bad_d      = 1'b0;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (in_req_mem_access) begin
                    req_d.addr        = in_addr;
                    req_d.data        = in_data;
                    req_d.access_type = in_access_type;
                    req_d.access_size = in_access_size;
                    if (legal_access(in_addr, in_access_size)) begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = (in_access_type == DiatWrite);
                        mem_addr_d = in_addr[31:2];
                        be_d       = byte_en_for(in_addr, in_access_size);
                        wdata_d    = wdata_rep;
                        wait_d     = 1'b1;
                        cnt_d      = '0;
                        state_d    = StBus;
                    end else begin
                        bad_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StBus: begin
                // An ack in the final timeout cycle still completes normally.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    wait_d    = 1'b0;
                    if (req_q.access_type == DiatRead) begin
                        out_data_d = rdata_aligned;
                    end
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    mem_req_d  = 1'b0;
                    out_data_d = 32'h0;
                    wait_d     = 1'b0;
                    bad_d      = 1'b1;
                    state_d    = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            req_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= 32'h0;
            wait_q     <= 1'b0;
            bad_q      <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 30'h0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            wait_q     <= wait_d;
            bad_q      <= bad_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
        end
    end

    assign out_data         = out_data_q;
    assign out_wait_for_mem = wait_q;
    assign out_bad_access   = bad_q;
    assign mem_req          = mem_req_q;
    assign mem_we           = mem_we_q;
    assign mem_addr         = mem_addr_q;
    assign mem_byte_en      = be_q;
    assign mem_wdata        = wdata_q;

endmodule

// File: tb/tb_frost32_mem_bus_ctrl.sv
// Testbench for frost32_mem_bus_ctrl: directed cases plus randomized
// transactions against a transaction-level reference model.
module tb_frost32_mem_bus_ctrl;
    import PkgFrost32Cpu::*;

    localparam int T = 8;

    logic               clk;
    logic               rst;
    logic               in_req_mem_access;
    logic [31:0]        in_addr;
    logic [31:0]        in_data;
    DataInoutAccessType in_access_type;
    DataInoutAccessSize in_access_size;
    logic [31:0]        out_data;
    logic               out_wait_for_mem;
    logic               out_bad_access;
    logic               mem_req;
    logic               mem_we;
    logic [29:0]        mem_addr;
    logic [3:0]         mem_byte_en;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;
    logic               mem_ack;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_out;

    frost32_mem_bus_ctrl #(
        .TIMEOUT_CYCLES (T),
        .CNT_WIDTH      (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .in_req_mem_access (in_req_mem_access),
        .in_addr           (in_addr),
        .in_data           (in_data),
        .in_access_type    (in_access_type),
        .in_access_size    (in_access_size),
        .out_data          (out_data),
        .out_wait_for_mem  (out_wait_for_mem),
        .out_bad_access    (out_bad_access),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_byte_en       (mem_byte_en),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input DataInoutAccessSize s);
        case (s)
            Dias32:  return 4;
            Dias16:  return 2;
            Dias8:   return 1;
            default: return 0;
        endcase
    endfunction

    function automatic bit m_legal(input logic [31:0] a,
                                   input DataInoutAccessSize s);
        int n;
        n = nbytes(s);
        if (n == 0) return 1'b0;
        return (a % n) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a,
                                        input DataInoutAccessSize s);
        logic [3:0] be;
        int off;
        be  = 4'h0;
        off = int'(a % 4);
        for (int i = off; i < off + nbytes(s); i++) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] d,
                                            input DataInoutAccessSize s);
        logic [31:0] w;
        int n;
        n = nbytes(s);
        w = 32'h0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] rd,
                                            input logic [31:0] a,
                                            input DataInoutAccessSize s);
        longint v;
        longint mask;
        v    = longint'(rd) / (longint'(1) << (8 * (a % 4)));
        mask = (longint'(1) << (8 * nbytes(s))) - 1;
        return 32'(v & mask);
    endfunction

    // Entered and left at a negedge with the controller idle.
    task automatic txn(input logic [31:0] a, input DataInoutAccessSize s,
                       input DataInoutAccessType t, input logic [31:0] d,
                       input logic [31:0] rd, input int ackc, input bit hold);
        bit lg;
        bit tmo;
        int done;
        in_addr           = a;
        in_data           = d;
        in_access_type    = t;
        in_access_size    = s;
        in_req_mem_access = 1'b1;
        mem_ack           = 1'b0;
        @(negedge clk);
        if (!hold) in_req_mem_access = 1'b0;
        lg = m_legal(a, s);
        if (!lg) begin
            chk("ill_bad", {31'h0, out_bad_access}, 32'h1);
            chk("ill_req", {31'h0, mem_req}, 32'h0);
            chk("ill_wait", {31'h0, out_wait_for_mem}, 32'h0);
            @(negedge clk);
            chk("ill_bad_clr", {31'h0, out_bad_access}, 32'h0);
            chk("ill_req2", {31'h0, mem_req}, 32'h0);
            chk("ill_wait2", {31'h0, out_wait_for_mem}, 32'h0);
            chk("ill_data", out_data, exp_out);
            return;
        end
        chk("req_rise", {31'h0, mem_req}, 32'h1);
        chk("wait_rise", {31'h0, out_wait_for_mem}, 32'h1);
        chk("we", {31'h0, mem_we}, {31'h0, t == DiatWrite});
        chk("addr", {2'b00, mem_addr}, a >> 2);
        chk("be", {28'h0, mem_byte_en}, {28'h0, m_be(a, s)});
        chk("wdata", mem_wdata, m_wdata(d, s));
        tmo  = !(ackc >= 1 && ackc <= T);
        done = tmo ? T : ackc;
        for (int c = 1; c <= done; c++) begin
            mem_ack   = (c == ackc);
            mem_rdata = (c == ackc) ? rd : $urandom;
            @(negedge clk);
            if (c < done) begin
                chk("req_hold", {31'h0, mem_req}, 32'h1);
                chk("wait_hold", {31'h0, out_wait_for_mem}, 32'h1);
                chk("bad_hold", {31'h0, out_bad_access}, 32'h0);
            end
        end
        mem_ack = 1'b0;
        if (tmo) exp_out = 32'h0;
        else if (t == DiatRead) exp_out = m_rdata(rd, a, s);
        chk("end_req", {31'h0, mem_req}, 32'h0);
        chk("end_wait", {31'h0, out_wait_for_mem}, 32'h0);
        chk("end_bad", {31'h0, out_bad_access}, {31'h0, tmo});
        chk("end_data", out_data, exp_out);
        // A stray ack while finishing must be ignored.
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("gap_req", {31'h0, mem_req}, 32'h0);
        chk("gap_bad", {31'h0, out_bad_access}, 32'h0);
        chk("gap_wait", {31'h0, out_wait_for_mem}, 32'h0);
        chk("gap_data", out_data, exp_out);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, out_data, 32'h0);
        chk({tag, "_wait"}, {31'h0, out_wait_for_mem}, 32'h0);
        chk({tag, "_bad"}, {31'h0, out_bad_access}, 32'h0);
        chk({tag, "_req"}, {31'h0, mem_req}, 32'h0);
        chk({tag, "_we"}, {31'h0, mem_we}, 32'h0);
        chk({tag, "_addr"}, {2'b00, mem_addr}, 32'h0);
        chk({tag, "_be"}, {28'h0, mem_byte_en}, 32'h0);
        chk({tag, "_wd"}, mem_wdata, 32'h0);
    endtask

    initial begin
        logic [31:0]        a;
        DataInoutAccessSize s;
        DataInoutAccessType t;
        n_checks          = 0;
        n_errors          = 0;
        exp_out           = 32'h0;
        rst               = 1'b1;
        in_req_mem_access = 1'b0;
        in_addr           = 32'h0;
        in_data           = 32'h0;
        in_access_type    = DiatRead;
        in_access_size    = Dias32;
        mem_rdata         = 32'h0;
        mem_ack           = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("rst");
        rst = 1'b0;
        @(negedge clk);

        txn(32'h100, Dias32, DiatRead, 32'h0, 32'hDEADBEEF, 4, 1'b0);
        chk("t1_data", out_data, 32'hDEADBEEF);
        txn(32'h103, Dias8, DiatRead, 32'h0, 32'h11223344, 2, 1'b0);
        chk("t2_be8", {28'h0, mem_byte_en}, 32'h8);
        chk("t2_d8", out_data, 32'h11);
        txn(32'h102, Dias16, DiatRead, 32'h0, 32'h11223344, 1, 1'b0);
        chk("t2_d16", out_data, 32'h1122);
        txn(32'h006, Dias16, DiatWrite, 32'hFFFFABCD, 32'h0, 3, 1'b0);
        chk("t3_we", {31'h0, mem_we}, 32'h1);
        chk("t3_be", {28'h0, mem_byte_en}, 32'hC);
        chk("t3_wd", mem_wdata, 32'hABCDABCD);
        chk("t3_data", out_data, 32'h1122);
        txn(32'h002, Dias32, DiatRead, 32'h0, 32'h0, 1, 1'b0);
        txn(32'h000, DiasBad, DiatRead, 32'h0, 32'h0, 1, 1'b0);
        txn(32'h200, Dias32, DiatRead, 32'h0, 32'h0, 0, 1'b0);
        chk("t5_tmo", out_data, 32'h0);
        txn(32'h204, Dias32, DiatRead, 32'h0, 32'hCAFEF00D, T, 1'b0);
        chk("t5_late", out_data, 32'hCAFEF00D);

        txn(32'h300, Dias32, DiatRead, 32'h0, 32'h01020304, 2, 1'b1);
        txn(32'h301, Dias8, DiatRead, 32'h0, 32'h01020304, 3, 1'b1);
        in_addr           = 32'h400;
        in_access_size    = Dias32;
        in_access_type    = DiatWrite;
        in_data           = 32'h55AA55AA;
        @(negedge clk);
        chk("rst_pre_req", {31'h0, mem_req}, 32'h1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("rst_mid");
        exp_out = 32'h0;
        @(negedge clk);
        rst               = 1'b0;
        in_req_mem_access = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_idle");
        txn(32'h404, Dias16, DiatRead, 32'h0, 32'h89ABCDEF, 1, 1'b0);

        for (int k = 0; k < 80; k++) begin
            a = $urandom;
            s = DataInoutAccessSize'(2'($urandom_range(0, 3)));
            t = DataInoutAccessType'(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) != 0) begin
                if (s == Dias32) a[1:0] = 2'b00;
                if (s == Dias16) a[0] = 1'b0;
            end
            txn(a, s, t, $urandom, $urandom, $urandom_range(0, T + 3), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
